// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared types and constants for the GMII receive MAC:
//                receiver state encoding, CRC-32 constants, preamble/SFD
//                byte values, delay-line depth and byte-counter width, plus
//                the one-byte CRC-32 update step.
//  Ports       : (package - none)
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_DROP     = 2'd3
   } state_t;

   // IEEE 802.3 CRC-32, reflected form
   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   // Register contents after running the CRC over a frame plus its correct FCS
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   // Bytes held back so that the 4 FCS bytes are never forwarded
   localparam int          HOLD_DEPTH = 5;
   localparam int          CNT_W      = 11;
   // Highest legal preamble-byte count before the SFD
   localparam logic [2:0]  PRE_LAST   = 3'd7;

   // One byte of reflected CRC-32, LSB of the data byte first
   function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                              input logic [7:0]  dat);
      logic [31:0] c;
      c = crc ^ {24'h00_0000, dat};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_d8
//  Description : Combinational CRC-32 (IEEE 802.3, reflected) update for one
//                8-bit data step. No final inversion is applied.
//  Ports       : crc      in  [31:0]  current CRC register value
//                dat      in  [7:0]   data byte
//                crc_next out [31:0]  CRC register value after this byte
//  Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8
   import mac_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [7:0]  dat,
   output logic [31:0] crc_next
);

   assign crc_next = crc32_step(crc, dat);

endmodule
`default_nettype wire

// File: rtl/mac_rx.sv
`default_nettype none
// ============================================================================
//  Module      : mac_rx
//  Description : GMII receive MAC. Locks onto preamble + SFD, strips them,
//                holds the last 5 bytes back so the FCS is never forwarded,
//                checks CRC-32 residue, minimum/maximum length and PHY error,
//                and reports frame status at the last emitted byte.
//  Ports       : clk            in   single clock (GMII RX domain)
//                arst_n         in   asynchronous active-low reset
//                gmii_rx_dat    in   [7:0] receive byte
//                gmii_rx_val    in   receive data valid
//                gmii_rx_err    in   receive error
//                out_dat        out  [7:0] frame byte (no preamble/SFD/FCS)
//                out_val        out  out_dat valid
//                out_sof        out  first byte of frame (with out_val)
//                out_eof        out  last byte of frame (with out_val)
//                out_err        out  frame bad (with out_eof)
//                stat_fcs_err   out  pulse: CRC residue mismatch
//                stat_len_err   out  pulse: frame too short or too long
//                stat_phy_err   out  pulse: gmii_rx_err seen inside frame
//                stat_runt      out  pulse: frame of 4 bytes or fewer
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_rx
   import mac_pkg::*;
#(
   parameter int MAX_LEN = 1522,
   parameter int MIN_LEN = 64
)
(
   input  logic       clk,
   input  logic       arst_n,
   input  logic [7:0] gmii_rx_dat,
   input  logic       gmii_rx_val,
   input  logic       gmii_rx_err,
   output logic [7:0] out_dat,
   output logic       out_val,
   output logic       out_sof,
   output logic       out_eof,
   output logic       out_err,
   output logic       stat_fcs_err,
   output logic       stat_len_err,
   output logic       stat_phy_err,
   output logic       stat_runt
);

   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_LEN);
   localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   state_t                           state_q, state_d;
   logic [2:0]                       pcnt_q, pcnt_d;
   // hold_q[0] is the newest byte, hold_q[HOLD_DEPTH-1] the oldest
   logic [HOLD_DEPTH-1:0][7:0]       hold_q, hold_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [31:0]                      crc_q, crc_d;
   logic                             phy_q, phy_d;
   logic                             sof_pend_q, sof_pend_d;

   logic [7:0]                       out_dat_d;
   logic                             out_val_d, out_sof_d, out_eof_d, out_err_d;
   logic                             stat_fcs_d, stat_len_d, stat_phy_d, stat_runt_d;

   logic [31:0]                      crc_next;
   logic                             phy_now;
   logic                             fcs_bad;
   logic                             too_short;

   crc32_d8 u_crc (
      .crc      (crc_q),
      .dat      (gmii_rx_dat),
      .crc_next (crc_next)
   );

   // ---------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      pcnt_d      = pcnt_q;
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      crc_d       = crc_q;
      phy_d       = phy_q;
      sof_pend_d  = sof_pend_q;
      out_dat_d   = 8'h00;
      out_val_d   = 1'b0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
      out_err_d   = 1'b0;
      stat_fcs_d  = 1'b0;
      stat_len_d  = 1'b0;
      stat_phy_d  = 1'b0;
      stat_runt_d = 1'b0;
      phy_now     = phy_q | gmii_rx_err;
      fcs_bad     = (crc_q != CRC_RESIDUE);
      too_short   = (cnt_q < MIN_CNT);

      case (state_q)
         ST_IDLE: begin
            if (gmii_rx_val) begin
               if (gmii_rx_dat == PREAMBLE_BYTE) begin
                  state_d = ST_PREAMBLE;
                  pcnt_d  = 3'd1;
               end else begin
                  state_d = ST_DROP;
               end
            end
         end

         ST_PREAMBLE: begin
            if (!gmii_rx_val) begin
               state_d = ST_IDLE;
            end else if (gmii_rx_err) begin
               state_d = ST_DROP;
            end else if (gmii_rx_dat == PREAMBLE_BYTE) begin
               // an eighth preamble byte is treated as a malformed start
               if (pcnt_q >= PRE_LAST) begin
                  state_d = ST_DROP;
               end else begin
                  pcnt_d = pcnt_q + 3'd1;
               end
            end else if ((gmii_rx_dat == SFD_BYTE) && (pcnt_q != 3'd0)) begin
               state_d    = ST_DATA;
               cnt_d      = '0;
               crc_d      = CRC_INIT;
               phy_d      = 1'b0;
               sof_pend_d = 1'b1;
               hold_d     = '0;
            end else begin
               state_d = ST_DROP;
            end
         end

         ST_DATA: begin
            if (gmii_rx_val) begin
               hold_d = {hold_q[HOLD_DEPTH-2:0], gmii_rx_dat};
               crc_d  = crc_next;
               cnt_d  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
               phy_d  = phy_now;
               if (cnt_q == MAX_CNT) begin
                  // this byte would exceed MAX_LEN: close the frame as bad
                  // on the oldest held byte and discard the remainder
                  out_val_d  = 1'b1;
                  out_dat_d  = hold_q[HOLD_DEPTH-1];
                  out_sof_d  = sof_pend_q;
                  out_eof_d  = 1'b1;
                  out_err_d  = 1'b1;
                  stat_len_d = 1'b1;
                  stat_phy_d = phy_now;
                  sof_pend_d = 1'b0;
                  state_d    = ST_DROP;
               end else if (cnt_q >= HOLD_CNT) begin
                  // delay line full: the oldest byte is now known not to be FCS
                  out_val_d  = 1'b1;
                  out_dat_d  = hold_q[HOLD_DEPTH-1];
                  out_sof_d  = sof_pend_q;
                  sof_pend_d = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
               if (cnt_q < HOLD_CNT) begin
                  stat_runt_d = 1'b1;
               end else begin
                  // the remaining 4 held bytes are the FCS
                  out_val_d  = 1'b1;
                  out_dat_d  = hold_q[HOLD_DEPTH-1];
                  out_sof_d  = sof_pend_q;
                  out_eof_d  = 1'b1;
                  out_err_d  = fcs_bad | too_short | phy_q;
                  stat_fcs_d = fcs_bad;
                  stat_len_d = too_short;
                  stat_phy_d = phy_q;
                  sof_pend_d = 1'b0;
               end
            end
         end

         ST_DROP: begin
            if (!gmii_rx_val) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q      <= ST_IDLE;
         pcnt_q       <= 3'd0;
         hold_q       <= '0;
         cnt_q        <= '0;
         crc_q        <= '0;
         phy_q        <= 1'b0;
         sof_pend_q   <= 1'b0;
         out_dat      <= 8'h00;
         out_val      <= 1'b0;
         out_sof      <= 1'b0;
         out_eof      <= 1'b0;
         out_err      <= 1'b0;
         stat_fcs_err <= 1'b0;
         stat_len_err <= 1'b0;
         stat_phy_err <= 1'b0;
         stat_runt    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pcnt_q       <= pcnt_d;
         hold_q       <= hold_d;
         cnt_q        <= cnt_d;
         crc_q        <= crc_d;
         phy_q        <= phy_d;
         sof_pend_q   <= sof_pend_d;
         out_dat      <= out_dat_d;
         out_val      <= out_val_d;
         out_sof      <= out_sof_d;
         out_eof      <= out_eof_d;
         out_err      <= out_err_d;
         stat_fcs_err <= stat_fcs_d;
         stat_len_err <= stat_len_d;
         stat_phy_err <= stat_phy_d;
         stat_runt    <= stat_runt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mac_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_rx
//  Description : Self-checking bench for mac_rx. Stimulus pushes expected
//                output bytes into a scoreboard queue; a monitor pops and
//                compares every emitted byte and counts status pulses.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_rx;

   typedef struct packed {
      logic [7:0] dat;
      logic       sof;
      logic       eof;
      logic       err;
   } exp_t;

   logic       clk;
   logic       arst_n;
   logic [7:0] gmii_rx_dat;
   logic       gmii_rx_val;
   logic       gmii_rx_err;
   logic [7:0] out_dat;
   logic       out_val;
   logic       out_sof;
   logic       out_eof;
   logic       out_err;
   logic       stat_fcs_err;
   logic       stat_len_err;
   logic       stat_phy_err;
   logic       stat_runt;

   exp_t       exp_q[$];
   logic [7:0] body[$];
   int         checks   = 0;
   int         failures = 0;
   int         n_fcs    = 0;
   int         n_len    = 0;
   int         n_phy    = 0;
   int         n_runt   = 0;

   mac_rx dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .gmii_rx_dat  (gmii_rx_dat),
      .gmii_rx_val  (gmii_rx_val),
      .gmii_rx_err  (gmii_rx_err),
      .out_dat      (out_dat),
      .out_val      (out_val),
      .out_sof      (out_sof),
      .out_eof      (out_eof),
      .out_err      (out_err),
      .stat_fcs_err (stat_fcs_err),
      .stat_len_err (stat_len_err),
      .stat_phy_err (stat_phy_err),
      .stat_runt    (stat_runt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (stat_fcs_err) n_fcs++;
         if (stat_len_err) n_len++;
         if (stat_phy_err) n_phy++;
         if (stat_runt)    n_runt++;
         if (out_val) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_out: got dat=%h sof=%b eof=%b, required no output",
                        out_dat, out_sof, out_eof);
            end else begin
               e = exp_q.pop_front();
               if (out_dat !== e.dat || out_sof !== e.sof || out_eof !== e.eof ||
                   (e.eof && out_err !== e.err)) begin
                  failures++;
                  $display("FAIL out_byte: got dat=%h sof=%b eof=%b err=%b, required dat=%h sof=%b eof=%b err=%b",
                           out_dat, out_sof, out_eof, out_err, e.dat, e.sof, e.eof, e.err);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------
   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   task automatic build(input int n, input int seed, input bit add_fcs);
      logic [31:0] c;
      body.delete();
      for (int i = 0; i < n; i++) body.push_back(8'((i + seed) & 255));
      if (add_fcs) begin
         c = 32'hFFFFFFFF;
         for (int i = 0; i < n; i++) c = crc_upd(c, body[i]);
         c = ~c;
         body.push_back(c[7:0]);
         body.push_back(c[15:8]);
         body.push_back(c[23:16]);
         body.push_back(c[31:24]);
      end
   endtask

   task automatic expect_bytes(input int n, input bit err, input bit with_eof);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.dat = body[i];
         e.sof = (i == 0);
         e.eof = with_eof && (i == n - 1);
         e.err = err && e.eof;
         exp_q.push_back(e);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic er);
      @(negedge clk);
      gmii_rx_val = v;
      gmii_rx_dat = d;
      gmii_rx_err = er;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic check_zero(input string name);
      logic [15:0] v;
      v = {out_dat, out_val, out_sof, out_eof, out_err,
           stat_fcs_err, stat_len_err, stat_phy_err, stat_runt};
      checks++;
      if (v !== 16'h0000) begin
         failures++;
         $display("FAIL %s: outputs=%h, required 0000", name, v);
      end
   endtask

   task automatic check_stats(input string name, input int f, input int l,
                              input int p, input int r);
      checks++;
      if (n_fcs != f || n_len != l || n_phy != p || n_runt != r) begin
         failures++;
         $display("FAIL %s_stats: got fcs=%0d len=%0d phy=%0d runt=%0d, required fcs=%0d len=%0d phy=%0d runt=%0d",
                  name, n_fcs, n_len, n_phy, n_runt, f, l, p, r);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain: got %0d bytes still expected, required 0", name, exp_q.size());
      end
      exp_q.delete();
      n_fcs = 0; n_len = 0; n_phy = 0; n_runt = 0;
   endtask

   // 7x preamble + SFD, then body; optional bad preamble byte, PHY error
   // byte and reset pulse index; ends with one idle cycle
   task automatic send_frame(input int pre_bad, input int err_idx, input int rst_idx);
      logic [7:0] b;
      for (int p = 0; p < 8; p++) begin
         b = (p < 7) ? 8'h55 : 8'hD5;
         if (p == pre_bad) b = 8'h54;
         drive(1'b1, b, 1'b0);
      end
      for (int i = 0; i < body.size(); i++) begin
         drive(1'b1, body[i], (i == err_idx));
         arst_n = 1'b1;
         if (i == rst_idx) begin
            arst_n = 1'b0;
            #1;
            check_zero("reset_mid_frame");
         end
      end
      drive(1'b0, 8'h00, 1'b0);
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      arst_n      = 1'b0;
      gmii_rx_val = 1'b0;
      gmii_rx_dat = 8'h00;
      gmii_rx_err = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      arst_n = 1'b1;
      idle(3);

      // two good frames back to back (new preamble right after val falls)
      build(60, 1, 1);   expect_bytes(60, 0, 1); send_frame(-1, -1, -1);
      build(60, 100, 1); expect_bytes(60, 0, 1); send_frame(-1, -1, -1);
      idle(6); check_stats("good_b2b", 0, 0, 0, 0);

      // one payload bit flipped after FCS computed
      build(60, 1, 1); body[10] = body[10] ^ 8'h04;
      expect_bytes(60, 1, 1); send_frame(-1, -1, -1);
      idle(6); check_stats("fcs_err", 1, 0, 0, 0);

      // 40-byte frame with valid FCS
      build(36, 7, 1); expect_bytes(36, 1, 1); send_frame(-1, -1, -1);
      idle(6); check_stats("short", 0, 1, 0, 0);

      // 3-byte runt
      build(3, 9, 0); send_frame(-1, -1, -1);
      idle(6); check_stats("runt", 0, 0, 0, 1);

      // 1600-byte frame, then a clean frame
      build(1600, 0, 0); expect_bytes(1518, 1, 1); send_frame(-1, -1, -1);
      idle(6); check_stats("long", 0, 1, 0, 0);
      build(60, 33, 1); expect_bytes(60, 0, 1); send_frame(-1, -1, -1);
      idle(6); check_stats("after_long", 0, 0, 0, 0);

      // PHY error on payload byte 20
      build(60, 2, 1); expect_bytes(60, 1, 1); send_frame(-1, 20, -1);
      idle(6); check_stats("phy_err", 0, 0, 1, 0);

      // bad preamble byte 0x54
      build(60, 3, 1); send_frame(2, -1, -1);
      idle(6); check_stats("bad_preamble", 0, 0, 0, 0);

      // reset at payload byte 30: bytes 0..24 already out, no eof; then a
      // back-to-back good frame
      build(60, 0, 1); expect_bytes(25, 0, 0); send_frame(-1, -1, 30);
      build(60, 50, 1); expect_bytes(60, 0, 1); send_frame(-1, -1, -1);
      idle(6); check_stats("reset_recover", 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mac_rx.md
MAC_RX -- requirements
Module: mac_rx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1522, maximum frame bytes after SFD including FCS.
REQ-002 SHALL have parameter MIN_LEN, default 64, minimum frame bytes after SFD including FCS.
REQ-003 SHALL have port clk, input, 1, the single clock, same domain as the GMII RX byte stream.
REQ-004 SHALL have port arst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports gmii_rx_dat/gmii_rx_val/gmii_rx_err, input, 8/1/1, GMII receive byte, data-valid and error.
REQ-006 SHALL have ports out_dat/out_val, output, 8/1, frame byte with preamble, SFD and FCS removed.
REQ-007 SHALL have ports out_sof/out_eof, output, 1/1, first/last byte markers, qualified by out_val.
REQ-008 SHALL have port out_err, output, 1, frame bad, qualified by out_eof.
REQ-009 SHALL have ports stat_fcs_err/stat_len_err/stat_phy_err/stat_runt, output, 1 each, single-cycle event pulses.

Function
REQ-010 SHALL implement states IDLE, PREAMBLE, DATA and DROP.
REQ-011 IDLE: val=1 with 0x55 -> PREAMBLE (preamble count=1); val=1 with any other byte -> DROP.
REQ-012 PREAMBLE: 0x55 -> count+1; 0xD5 with count 1..7 -> DATA; count>7, other byte, or err=1 -> DROP; val=0 -> IDLE.
REQ-013 DROP SHALL discard bytes until val=0, then -> IDLE; an entry from PREAMBLE asserts no status pulse.
REQ-014 DATA SHALL push each valid byte into a 5-byte delay line and increment a 11-bit byte counter (saturating at 2047).
REQ-015 A held byte SHALL be emitted on out_dat/out_val in the cycle after the 5th subsequent byte arrives; out_sof marks the first emitted byte.
REQ-016 On val falling in DATA, the oldest held byte SHALL be emitted next cycle with out_eof=1; the 4 remaining bytes are FCS and are not emitted.
REQ-017 CRC-32 (IEEE 802.3, reflected, init 0xFFFFFFFF) SHALL run over every byte after SFD including FCS; a good frame leaves register residue 0xDEBB20E3.
REQ-018 out_err at eof SHALL be OR of: residue mismatch, count<MIN_LEN, any gmii_rx_err=1 during DATA.
REQ-019 count reaching MAX_LEN+1 SHALL force eof with out_err=1 on the held byte, pulse stat_len_err, -> DROP.
REQ-020 Frame ending with count<=4 SHALL emit nothing, pulse stat_runt, -> IDLE.
REQ-021 stat_fcs_err, stat_len_err (short or long) and stat_phy_err SHALL pulse in the eof cycle for their cause; multiple may pulse together.
REQ-022 out_val SHALL never assert outside DATA-derived emission; no back-pressure exists; one byte per cycle maximum.
REQ-023 A new preamble arriving the cycle after val falls SHALL be accepted while the eof byte is emitted.

Reset
REQ-024 arst_n low SHALL force IDLE, clear delay line, counters and CRC, and drive every output to 0.
REQ-025 Reset released mid-frame SHALL land in DROP via REQ-011 (non-0x55) or emit nothing until a complete preamble+SFD.

Structure
REQ-026 Package mac_pkg SHALL hold the state enum, CRC polynomial 0xEDB88320, init and residue constants, SFD/preamble byte constants.
REQ-027 Sub-module crc32_d8 (combinational, 8-bit-per-step CRC update) SHALL be instantiated once.

Verification
REQ-028 7x0x55, 0xD5, 60 payload + correct FCS -> 60 out bytes, sof on byte 0, eof on byte 59, out_err=0.
REQ-029 Same frame with one payload bit flipped -> 60 bytes, out_err=1, stat_fcs_err pulse.
REQ-030 Frame of 40 bytes with valid FCS -> 36 bytes, out_err=1, stat_len_err pulse; 3-byte frame -> no output, stat_runt pulse.
REQ-031 1600-byte frame -> eof after 1518 emitted bytes with out_err=1, rest dropped, next frame received cleanly.
REQ-032 gmii_rx_err=1 on one payload byte -> out_err=1, stat_phy_err; preamble byte 0x54 -> no output.
REQ-033 arst_n pulsed at payload byte 30 -> outputs 0 immediately, no eof for that frame, following back-to-back frame (1-cycle gap) received correctly.
